fsm_ctrl_param: RTL and testbench

Parametrised successor to the switch-controller FSM that supervises the main FIFO (MF) and the virtual-channel (VC) and destination (D) FIFOs.
- Latches per-class empty/full thresholds during init and validates them.
- Tracks idle/active from FIFO empty flags.
- Enters a sticky error state that records which FIFO faulted.
- Generalises the fixed two-VC/two-D controller to NUM_VC and NUM_D channels.
- Adds threshold validation, an error-source capture vector and a saturating error counter.

---
 rtl/fsm_ctrl_pkg.sv | 40 ++++
 rtl/fsm_ctrl_param_umbral_reg.sv | 30 +++
 rtl/fsm_ctrl_param.sv | 122 ++++++++++++
 tb/tb_fsm_ctrl_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared state encoding and channel-map helpers for the parametrised FIFO supervisor.
package fsm_ctrl_pkg;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  typedef enum logic [4:0] {
    ST_RESET  = S_RESET,
    ST_INIT   = S_INIT,
    ST_IDLE   = S_IDLE,
    ST_ACTIVE = S_ACTIVE,
    ST_ERROR  = S_ERROR
  } state_t;

  localparam int MF_IDX = 0;
  localparam int CLS_MF = 0;
  localparam int CLS_VC = 1;
  localparam int CLS_D  = 2;

  // Channel bit range of a FIFO class inside the NCH-wide flag vectors.
  function automatic int ch_lo(input int cls, input int num_vc);
    case (cls)
      CLS_VC:  ch_lo = 1;
      CLS_D:   ch_lo = num_vc + 1;
      default: ch_lo = MF_IDX;
    endcase
  endfunction

  function automatic int ch_hi(input int cls, input int num_vc, input int num_d);
    case (cls)
      CLS_VC:  ch_hi = num_vc;
      CLS_D:   ch_hi = num_vc + num_d;
      default: ch_hi = MF_IDX;
    endcase
  endfunction

endpackage

// File: rtl/fsm_ctrl_param_umbral_reg.sv
// Empty/full threshold pair: loads only when empty < full, otherwise flags a sticky reject.
module umbral_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [W-1:0] empty_in,
  input  logic [W-1:0] full_in,
  output logic [W-1:0] empty_out,
  output logic [W-1:0] full_out,
  output logic         cfg_err
);

  always_ff @(posedge clk) begin
    if (reset) begin
      empty_out <= '0;
      full_out  <= '0;
      cfg_err   <= 1'b0;
    end else if (load_en) begin
      if (empty_in < full_in) begin
        empty_out <= empty_in;
        full_out  <= full_in;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_ctrl_param.sv
// Supervisor FSM for the MF, VC and D FIFOs: threshold setup, idle/active tracking, sticky error.
//   state  | meaning
//   RESET  | held in reset, all indicators low
//   INIT   | thresholds validated and loaded every edge
//   IDLE   | all FIFOs empty
//   ACTIVE | at least one FIFO holds data
//   ERROR  | a FIFO faulted; sticky until reset
module fsm_ctrl_param
  import fsm_ctrl_pkg::*;
#(
  parameter int MF_SIZE  = 3,
  parameter int VC_SIZE  = 3,
  parameter int D_SIZE   = 3,
  parameter int NUM_VC   = 2,
  parameter int NUM_D    = 2,
  parameter int ERRCNT_W = 4,
  localparam int NCH     = 1 + NUM_VC + NUM_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [MF_SIZE-1:0]  MF_empty_umbral_in,
  input  logic [MF_SIZE-1:0]  MF_full_umbral_in,
  input  logic [VC_SIZE-1:0]  VC_empty_umbral_in,
  input  logic [VC_SIZE-1:0]  VC_full_umbral_in,
  input  logic [D_SIZE-1:0]   D_empty_umbral_in,
  input  logic [D_SIZE-1:0]   D_full_umbral_in,
  input  logic [NCH-1:0]      err_sig_in,
  input  logic [NCH-1:0]      empty_sig_in,
  output logic [MF_SIZE-1:0]  MF_empty_umbral_out,
  output logic [MF_SIZE-1:0]  MF_full_umbral_out,
  output logic [VC_SIZE-1:0]  VC_empty_umbral_out,
  output logic [VC_SIZE-1:0]  VC_full_umbral_out,
  output logic [D_SIZE-1:0]   D_empty_umbral_out,
  output logic [D_SIZE-1:0]   D_full_umbral_out,
  output logic [2:0]          cfg_err_out,
  output logic [NCH-1:0]      err_src_out,
  output logic [ERRCNT_W-1:0] err_cnt_out,
  output logic                error_out,
  output logic                active_out,
  output logic                idle_out,
  output logic                init_out
);

  state_t state, state_nxt;
  logic   any_err, all_empty, operating, err_entry;
  logic   mf_err, vc_err, d_err;

  assign any_err   = |err_sig_in;
  assign all_empty = &empty_sig_in;
  assign operating = (state == ST_INIT) || (state == ST_IDLE) || (state == ST_ACTIVE);
  assign err_entry = operating && any_err;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT: begin
        if (any_err)    state_nxt = ST_ERROR;
        else if (!init) state_nxt = all_empty ? ST_IDLE : ST_ACTIVE;
      end
      ST_IDLE: begin
        if (any_err)         state_nxt = ST_ERROR;
        else if (init)       state_nxt = ST_INIT;
        else if (!all_empty) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err)        state_nxt = ST_ERROR;
        else if (init)      state_nxt = ST_INIT;
        else if (all_empty) state_nxt = ST_IDLE;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Source vector restarts on entry and accumulates while parked in ERROR.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_src_out <= '0;
      err_cnt_out <= '0;
    end else if (err_entry) begin
      err_src_out <= err_sig_in;
      if (err_cnt_out != '1) err_cnt_out <= err_cnt_out + 1'b1;
    end else if (state == ST_ERROR) begin
      err_src_out <= err_src_out | err_sig_in;
    end
  end

  umbral_reg #(.W(MF_SIZE)) u_mf (
    .clk(clk), .reset(reset), .load_en(state == ST_INIT),
    .empty_in(MF_empty_umbral_in), .full_in(MF_full_umbral_in),
    .empty_out(MF_empty_umbral_out), .full_out(MF_full_umbral_out),
    .cfg_err(mf_err)
  );

  umbral_reg #(.W(VC_SIZE)) u_vc (
    .clk(clk), .reset(reset), .load_en(state == ST_INIT),
    .empty_in(VC_empty_umbral_in), .full_in(VC_full_umbral_in),
    .empty_out(VC_empty_umbral_out), .full_out(VC_full_umbral_out),
    .cfg_err(vc_err)
  );

  umbral_reg #(.W(D_SIZE)) u_d (
    .clk(clk), .reset(reset), .load_en(state == ST_INIT),
    .empty_in(D_empty_umbral_in), .full_in(D_full_umbral_in),
    .empty_out(D_empty_umbral_out), .full_out(D_full_umbral_out),
    .cfg_err(d_err)
  );

  assign cfg_err_out = {d_err, vc_err, mf_err};
  assign error_out   = (state == ST_ERROR);
  assign active_out  = (state == ST_ACTIVE);
  assign idle_out    = (state == ST_IDLE);
  assign init_out    = (state == ST_INIT);

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Scoreboard bench: a rule-level model predicts every post-edge output and a monitor compares.
module tb_fsm_ctrl_param;
  import fsm_ctrl_pkg::*;

  localparam int W   = 3;
  localparam int NVC = 2;
  localparam int ND  = 2;
  localparam int CW  = 4;
  localparam int N   = 1 + NVC + ND;

  logic clk = 1'b0;
  logic reset, init;
  logic [W-1:0] mfe_i, mff_i, vce_i, vcf_i, de_i, df_i;
  logic [N-1:0] err_i, emp_i;
  logic [W-1:0] mfe_o, mff_o, vce_o, vcf_o, de_o, df_o;
  logic [2:0]   cfg_o;
  logic [N-1:0] src_o;
  logic [CW-1:0] cnt_o;
  logic err_o, act_o, idle_o, init_o;

  always #5 clk = ~clk;

  fsm_ctrl_param #(.MF_SIZE(W), .VC_SIZE(W), .D_SIZE(W), .NUM_VC(NVC), .NUM_D(ND),
                   .ERRCNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .MF_empty_umbral_in(mfe_i), .MF_full_umbral_in(mff_i),
    .VC_empty_umbral_in(vce_i), .VC_full_umbral_in(vcf_i),
    .D_empty_umbral_in(de_i), .D_full_umbral_in(df_i),
    .err_sig_in(err_i), .empty_sig_in(emp_i),
    .MF_empty_umbral_out(mfe_o), .MF_full_umbral_out(mff_o),
    .VC_empty_umbral_out(vce_o), .VC_full_umbral_out(vcf_o),
    .D_empty_umbral_out(de_o), .D_full_umbral_out(df_o),
    .cfg_err_out(cfg_o), .err_src_out(src_o), .err_cnt_out(cnt_o),
    .error_out(err_o), .active_out(act_o), .idle_out(idle_o), .init_out(init_o)
  );

  // Model: mode 0=reset 1=init 2=idle 3=active 4=error
  typedef struct {
    int mode;
    int e[3];
    int f[3];
    int cfg[3];
    int src;
    int cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit stim_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input bit ini,
                                     input int ein[3], input int fin[3],
                                     input int err, input int emp);
    bit all_e;
    all_e = (emp == (1 << N) - 1);
    if (rst) begin
      m.mode = 0; m.src = 0; m.cnt = 0;
      for (int c = 0; c < 3; c++) begin m.e[c] = 0; m.f[c] = 0; m.cfg[c] = 0; end
      return;
    end
    if (m.mode == 1)
      for (int c = 0; c < 3; c++)
        if (ein[c] < fin[c]) begin m.e[c] = ein[c]; m.f[c] = fin[c]; end
        else m.cfg[c] = 1;
    if (m.mode == 4) m.src = m.src | err;
    else if (m.mode >= 1 && err != 0) begin
      m.src = err;
      m.cnt = (m.cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m.cnt + 1;
      m.mode = 4;
    end else if (m.mode == 0) m.mode = 1;
    else if (m.mode == 1) begin
      if (!ini) m.mode = all_e ? 2 : 3;
    end else begin
      if (ini) m.mode = 1;
      else m.mode = all_e ? 2 : 3;
    end
  endfunction

  task automatic cyc(input bit rst, input bit ini,
                     input int me, input int mf, input int ve, input int vf,
                     input int de, input int df, input int err, input int emp);
    int ein[3];
    int fin[3];
    @(posedge clk); #3;
    reset = rst; init = ini;
    mfe_i = W'(me); mff_i = W'(mf); vce_i = W'(ve); vcf_i = W'(vf);
    de_i = W'(de); df_i = W'(df);
    err_i = N'(err); emp_i = N'(emp);
    ein[0] = me; ein[1] = ve; ein[2] = de;
    fin[0] = mf; fin[1] = vf; fin[2] = df;
    model_step(rst, ini, ein, fin, err, emp);
    sb.push_back(m);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("init_out",   int'(init_o), int'(x.mode == 1));
        chk("idle_out",   int'(idle_o), int'(x.mode == 2));
        chk("active_out", int'(act_o),  int'(x.mode == 3));
        chk("error_out",  int'(err_o),  int'(x.mode == 4));
        chk("mf_thr", int'({mfe_o, mff_o}), (x.e[0] << W) | x.f[0]);
        chk("vc_thr", int'({vce_o, vcf_o}), (x.e[1] << W) | x.f[1]);
        chk("d_thr",  int'({de_o, df_o}),   (x.e[2] << W) | x.f[2]);
        chk("cfg_err", int'(cfg_o), (x.cfg[2] << 2) | (x.cfg[1] << 1) | x.cfg[0]);
        chk("err_src", int'(src_o), x.src);
        chk("err_cnt", int'(cnt_o), x.cnt);
      end
    end
  end

  initial begin : stim
    int all1, r, lo, hi, cls, em;
    all1 = (1 << N) - 1;
    reset = 1; init = 0; err_i = '0; emp_i = '1;
    mfe_i = '0; mff_i = '0; vce_i = '0; vcf_i = '0; de_i = '0; df_i = '0;
    m.mode = 0; m.src = 0; m.cnt = 0;
    for (int c = 0; c < 3; c++) begin m.e[c] = 0; m.f[c] = 0; m.cfg[c] = 0; end

    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, all1);
    cyc(0, 0, 1, 6, 2, 5, 1, 2, 0, all1);   // RESET -> INIT
    cyc(0, 0, 1, 6, 2, 5, 1, 2, 0, all1);   // INIT loads, exits to IDLE
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, all1);
    cyc(0, 1, 1, 6, 2, 5, 1, 2, 0, all1);
    cyc(0, 1, 1, 6, 2, 5, 1, 2, 0, all1);   // valid load
    cyc(0, 1, 7, 2, 3, 4, 0, 3, 0, all1);   // MF rejected
    cyc(0, 0, 1, 6, 2, 5, 1, 2, 0, all1);   // -> IDLE
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11011);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, all1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11011);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b11011);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b11011);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, all1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, all1);
    cyc(0, 1, 3, 4, 3, 4, 3, 4, 0, all1);
    cyc(0, 0, 3, 4, 3, 4, 3, 4, 0, all1);   // INIT -> IDLE
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 5'b10000, all1);  // error beats init
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, all1);

    for (int i = 0; i < 3000; i++) begin
      em = 0;
      if ($urandom_range(0, 15) == 0) begin
        cls = $urandom_range(0, 2);
        lo = ch_lo(cls, NVC);
        hi = ch_hi(cls, NVC, ND);
        em = 1 << $urandom_range(lo, hi);
        if ($urandom_range(0, 3) == 0) em = em | int'($urandom_range(0, all1));
      end
      r = ($urandom_range(0, 1) == 0) ? all1 : int'($urandom_range(0, all1));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), em, r);
    end

    @(posedge clk); #3;
    stim_done = 1;
  end

  initial begin : finisher
    int waited;
    wait (stim_done);
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    if (sb.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
